// File: rtl/if_id_reg_pkg.sv
// Shared pipeline constants and the F->D register bundle.
// Used by the pc, CP0 and IF/ID blocks.
package if_id_reg_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [31:0] NOP       = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  excode;
    logic        bd;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{
    instr:  NOP,
    pc:     PC_RESET,
    excode: EXC_NONE,
    bd:     1'b0,
    valid:  1'b0
  };

  localparam if_id_t IF_ID_EXC = '{
    instr:  NOP,
    pc:     EXC_ENTRY,
    excode: EXC_NONE,
    bd:     1'b0,
    valid:  1'b0
  };

endpackage

// File: rtl/if_id_reg_if.sv
// F->D bundle: fetch side drives, decode side consumes.
// Control and F fields flow in, D fields flow out.
interface if_id_reg_if;

  logic        en;
  logic        flush;
  logic        exc_flush;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [4:0]  excode_F;
  logic        bd_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic [4:0]  excode_D;
  logic        bd_D;
  logic        valid_D;

  modport master (
    output en, flush, exc_flush,
    output instr_F, pc_F, excode_F, bd_F,
    input  instr_D, pc_D, pc8_D,
    input  excode_D, bd_D, valid_D
  );

  modport slave (
    input  en, flush, exc_flush,
    input  instr_F, pc_F, excode_F, bd_F,
    output instr_D, pc_D, pc8_D,
    output excode_D, bd_D, valid_D
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, bubble flush and
// exception flush; pc8_D is the link address.
module if_id_reg
  import if_id_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        exc_flush,
  input  logic [31:0] instr_F,
  input  logic [31:0] pc_F,
  input  logic [4:0]  excode_F,
  input  logic        bd_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic [4:0]  excode_D,
  output logic        bd_D,
  output logic        valid_D
);

  if_id_t d_q, d_d;

  always_comb begin
    d_d = d_q;
    if (exc_flush) begin
      d_d = IF_ID_EXC;
    end else if (!en) begin
      d_d = d_q;
    end else if (flush) begin
      // Bubble keeps PC/BD so an interrupt on it reports a sane EPC
      d_d.instr  = NOP;
      d_d.pc     = pc_F;
      d_d.excode = EXC_NONE;
      d_d.bd     = bd_F;
      d_d.valid  = 1'b0;
    end else begin
      d_d.instr  = (excode_F == EXC_NONE) ? instr_F : NOP;
      d_d.pc     = pc_F;
      d_d.excode = excode_F;
      d_d.bd     = bd_F;
      d_d.valid  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= IF_ID_RESET;
    else       d_q <= d_d;
  end

  assign instr_D  = d_q.instr;
  assign pc_D     = d_q.pc;
  assign pc8_D    = d_q.pc + 32'd8;
  assign excode_D = d_q.excode;
  assign bd_D     = d_q.bd;
  assign valid_D  = d_q.valid;

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port en, input, 1 bit: load enable; 0 = stall, hold all D-stage state.
REQ-004 SHALL have port flush, input, 1 bit: insert a bubble into D while preserving the slot's PC and BD context.
REQ-005 SHALL have port exc_flush, input, 1 bit: exception/interrupt/eret taken; clear D completely.
REQ-006 SHALL have port instr_F, input, 32 bits: instruction fetched at pc_F.
REQ-007 SHALL have port pc_F, input, 32 bits: fetch-stage PC.
REQ-008 SHALL have port excode_F, input, 5 bits: fetch exception code; 0 = none, 4 = AdEL.
REQ-009 SHALL have port bd_F, input, 1 bit: fetched instruction sits in a branch delay slot.
REQ-010 SHALL have port instr_D, output, 32 bits: decode-stage instruction.
REQ-011 SHALL have port pc_D, output, 32 bits: decode-stage PC.
REQ-012 SHALL have port pc8_D, output, 32 bits: pc_D + 8, the link address.
REQ-013 SHALL have port excode_D, output, 5 bits: registered fetch exception code.
REQ-014 SHALL have port bd_D, output, 1 bit: registered delay-slot flag.
REQ-015 SHALL have port valid_D, output, 1 bit: 1 = D holds a real instruction; 0 = bubble.

Function
REQ-016 SHALL evaluate on each rising clk edge with reset low, in priority order: exc_flush > en = 0 (hold) > flush > normal load.
REQ-017 SHALL, on normal load (en = 1, flush = 0, exc_flush = 0), register pc_F, excode_F and bd_F.
REQ-018 SHALL, on normal load, set valid_D = 1 and instr_D = instr_F when excode_F == 0.
REQ-019 SHALL, on normal load with excode_F != 0, set instr_D = 32'h0 (nop) and valid_D = 1, so the fetch exception is reported from D.
REQ-020 SHALL, on flush (en = 1, exc_flush = 0), set instr_D = 0, excode_D = 0 and valid_D = 0, while still loading pc_D = pc_F and bd_D = bd_F so that an interrupt taken on the bubble reports a correct EPC.
REQ-021 SHALL, on exc_flush (regardless of en), set instr_D = 0, excode_D = 0, bd_D = 0, valid_D = 0 and pc_D = 32'h00004180.
REQ-022 SHALL, on stall (en = 0, exc_flush = 0), hold every register unchanged, irrespective of flush.
REQ-023 SHALL produce pc8_D combinationally as pc_D + 8 modulo 2^32; wrap-around is not flagged.
REQ-024 SHALL give a one-cycle latency from F inputs to D outputs.
REQ-025 SHALL treat flush and exc_flush asserted together as exc_flush.

Reset
REQ-026 SHALL, while reset = 1, asynchronously force instr_D = 0, pc_D = 32'h00003000, excode_D = 0, bd_D = 0 and valid_D = 0.
REQ-027 SHALL, while reset = 1, drive pc8_D = 32'h00003008.
REQ-028 SHALL let reset override en, flush and exc_flush.
REQ-029 SHALL, on reset asserted mid-stall, discard the held instruction; the first edge after deassertion is a normal load.

Structure
REQ-030 SHALL take the constants PC_RESET (32'h00003000), EXC_ENTRY (32'h00004180), EXC_NONE (0), EXC_ADEL (4) and NOP (32'h0) from the shared pipeline constants package, also used by pc and the CP0 block.
REQ-031 SHALL be a single flat module with no sub-modules.

Verification
REQ-032 SHALL cover: reset pulse mid-cycle -> pc_D = 3000 and valid_D = 0 immediately; after release, pc_F = 3000, instr_F = 24010005 -> next edge instr_D = 24010005, pc8_D = 3008, valid_D = 1.
REQ-033 SHALL cover: en = 0 for 3 cycles with instr_F changing -> instr_D and pc_D unchanged; flush = 1 during the stall -> still unchanged.
REQ-034 SHALL cover: flush = 1, pc_F = 3010, bd_F = 1 -> instr_D = 0, valid_D = 0, pc_D = 3010, bd_D = 1.
REQ-035 SHALL cover: exc_flush = 1 with en = 0 and flush = 1 -> pc_D = 4180, bd_D = 0, valid_D = 0, excode_D = 0.
REQ-036 SHALL cover: pc_F = 3002, excode_F = 4, instr_F = FFFFFFFF -> instr_D = 0, excode_D = 4, valid_D = 1.
REQ-037 SHALL cover: pc_F = FFFFFFFC -> pc8_D = 00000004.
